neuromorphic_x1_cmd_seq: RTL

NEUROMORPHIC_X1_CMD_SEQ -- requirements
Module: neuromorphic_x1_cmd_seq

---
 rtl/neuromorphic_x1_cmd_seq_pkg.sv | 28 ++
 rtl/neuromorphic_x1_cmd_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/neuromorphic_x1_cmd_seq_pkg.sv
// Shared definitions for the neuromorphic X1 command sequencer: command modes,
// the core's "no result yet" marker, FSM states and command-word packing.
package neuromorphic_x1_cmd_seq_pkg;

    localparam logic [1:0]  MODE_PROGRAM = 2'b11;
    localparam logic [1:0]  MODE_READ    = 2'b01;
    localparam logic [31:0] EMPTY_MARKER = 32'hDEAD_C0DE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_GAP,
        ST_RD_REQ,
        ST_RSP
    } state_t;

    // READ commands never carry a data payload to the core.
    function automatic logic [31:0] pack_cmd(input logic       op,
                                             input logic [4:0] row,
                                             input logic [4:0] col,
                                             input logic [7:0] data);
        if (op)
            pack_cmd = {MODE_PROGRAM, row, col, 12'b0, data};
        else
            pack_cmd = {MODE_READ, row, col, 12'b0, 8'h00};
    endfunction

endpackage

// File: rtl/neuromorphic_x1_cmd_seq.sv
// Sequences PROGRAM/READ commands to the X1 core over Wishbone: writes the command
// word, then for READ polls the result address until a valid bit or a timeout.
module neuromorphic_x1_cmd_seq
    import neuromorphic_x1_cmd_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_MATCH = 32'h3000_000C,
    parameter int unsigned POLL_GAP   = 8,
    parameter int unsigned MAX_POLLS  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [4:0]  cmd_row,
    input  logic [4:0]  cmd_col,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_bit,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);
    localparam logic [7:0] POLL_MAX = 8'(MAX_POLLS);

    state_t      state_q, state_d;
    logic        is_prog_q, is_prog_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [7:0]  poll_next;
    logic        cmd_ready_q, cmd_ready_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] dat_q, dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_bit_q, rsp_bit_d;
    logic        rsp_err_q, rsp_err_d;

    assign poll_next = poll_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        is_prog_d   = is_prog_q;
        gap_cnt_d   = gap_cnt_q;
        poll_cnt_d  = poll_cnt_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_bit_d   = rsp_bit_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    is_prog_d   = cmd_op;
                    dat_d       = pack_cmd(cmd_op, cmd_row, cmd_col, cmd_data);
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = 1'b1;
                    state_d     = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    if (is_prog_q) begin
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        poll_cnt_d = 8'd0;
                        gap_cnt_d  = 8'd0;
                        state_d    = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // The cycle after an ack is the first idle cycle of the gap.
                if (gap_cnt_q == GAP_LAST) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ST_RD_REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            ST_RD_REQ: begin
                if (wbm_ack_i) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (wbm_dat_i == EMPTY_MARKER) begin
                        if (poll_next == POLL_MAX) begin
                            rsp_valid_d = 1'b1;
                            rsp_bit_d   = 1'b0;
                            rsp_err_d   = 1'b1;
                            state_d     = ST_RSP;
                        end else begin
                            poll_cnt_d = poll_next;
                            gap_cnt_d  = 8'd0;
                            state_d    = ST_GAP;
                        end
                    end else begin
                        // Anything but a lone result bit is a malformed reply.
                        rsp_valid_d = 1'b1;
                        rsp_bit_d   = wbm_dat_i[0];
                        rsp_err_d   = (wbm_dat_i[31:1] != 31'd0);
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_bit_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            is_prog_q   <= 1'b0;
            gap_cnt_q   <= 8'd0;
            poll_cnt_q  <= 8'd0;
            cmd_ready_q <= 1'b1;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_bit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_prog_q   <= is_prog_d;
            gap_cnt_q   <= gap_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_bit_q   <= rsp_bit_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_bit   = rsp_bit_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_dat_o = dat_q;
    assign wbm_adr_o = ADDR_MATCH;
    assign wbm_sel_o = 4'hF;
    assign busy      = (state_q != ST_IDLE);

endmodule
